// File: rtl/resize_bist_ctrl.sv
// Self-test sequencer/checker for the bicubic resize engine: walks NUM_PAT configs, runs the engine,
// scans results against two golden planes. Optional macro RESIZE_CHK_TOL_EN adds a +/-TOL match on GOLD1.
module resize_bist_ctrl #(
    parameter int NUM_PAT   = 3,
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 10,
    parameter int CNT_W     = 16,
    parameter int MAX_CYCLE = 50000,
    parameter int RST_HOLD  = 2,
    parameter int LOW_WAIT  = 11
`ifdef RESIZE_CHK_TOL_EN
    ,
    parameter int TOL       = 1
`endif
) (
    input  logic                                           CLK,
    input  logic                                           RST_N,
    input  logic                                           START,
    output logic [((NUM_PAT > 1) ? $clog2(NUM_PAT) : 1)-1:0] CFG_IDX,
    input  logic [6:0]                                     CFG_H0,
    input  logic [6:0]                                     CFG_V0,
    input  logic [4:0]                                     CFG_SW,
    input  logic [4:0]                                     CFG_SH,
    input  logic [5:0]                                     CFG_TW,
    input  logic [5:0]                                     CFG_TH,
    output logic [6:0]                                     H0,
    output logic [6:0]                                     V0,
    output logic [4:0]                                     SW,
    output logic [4:0]                                     SH,
    output logic [5:0]                                     TW,
    output logic [5:0]                                     TH,
    output logic                                           DUT_RST,
    input  logic                                           DUT_DONE,
    output logic                                           RD_EN,
    output logic [ADDR_W-1:0]                              RD_ADDR,
    input  logic [PIX_W-1:0]                               RES_DATA,
    input  logic [PIX_W-1:0]                               GOLD1,
    input  logic [PIX_W-1:0]                               GOLD2,
    output logic                                           BUSY,
    output logic                                           END,
    output logic                                           PASS,
    output logic                                           TIMEOUT,
    output logic                                           PROTO_ERR,
    output logic [CNT_W-1:0]                               ERR_CNT
);

    localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
    localparam int NPX_W  = ADDR_W + 2;
    localparam int CYC_W  = $clog2(MAX_CYCLE + 1);
    localparam int WC_MAX = (RST_HOLD > LOW_WAIT) ? RST_HOLD : LOW_WAIT;
    localparam int WC_W   = $clog2(WC_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_DRST, S_WLOW, S_RUN, S_CHK, S_DRAIN, S_NEXT, S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [6:0]         r_h0, r_v0;
    logic [4:0]         r_sw, r_sh;
    logic [5:0]         r_tw, r_th;
    logic [WC_W-1:0]    r_wcnt;
    logic [CYC_W-1:0]   r_cyc;
    logic [NPX_W-1:0]   r_addr;
    logic               r_cmp_vld;
    logic [CNT_W-1:0]   r_err;
    logic               r_timeout;
    logic               r_proto;

    logic [NPX_W-1:0]   w_npix;
    logic               w_last_pix;
    logic               w_mismatch;
    logic               w_start_run;
    logic               w_set_to;
    logic               w_set_pe;

    assign w_npix     = NPX_W'(r_tw) * NPX_W'(r_th);
    assign w_last_pix = (r_addr == w_npix - 1'b1);

`ifdef RESIZE_CHK_TOL_EN
    logic [PIX_W:0] w_diff;
    assign w_diff     = (RES_DATA >= GOLD1) ? ({1'b0, RES_DATA} - {1'b0, GOLD1})
                                            : ({1'b0, GOLD1} - {1'b0, RES_DATA});
    assign w_mismatch = (RES_DATA != GOLD1) && (RES_DATA != GOLD2) && (w_diff > (PIX_W+1)'(TOL));
`else
    assign w_mismatch = (RES_DATA != GOLD1) && (RES_DATA != GOLD2);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        w_set_to    = 1'b0;
        w_set_pe    = 1'b0;
        case (r_state)
            S_IDLE, S_FIN: begin
                if (START) begin
                    w_start_run = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: w_state_nxt = S_DRST;
            S_DRST: begin
                if (r_wcnt == WC_W'(RST_HOLD - 1)) w_state_nxt = S_WLOW;
            end
            // DONE high here is stale from the previous run, never a completion
            S_WLOW: begin
                if (!DUT_DONE) begin
                    w_state_nxt = S_RUN;
                end else if (r_wcnt == WC_W'(LOW_WAIT)) begin
                    w_set_pe    = 1'b1;
                    w_state_nxt = S_FIN;
                end
            end
            S_RUN: begin
                if (DUT_DONE) begin
                    w_state_nxt = (w_npix == '0) ? S_NEXT : S_CHK;
                end else if (r_cyc == CYC_W'(MAX_CYCLE)) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = S_FIN;
                end
            end
            S_CHK: begin
                if (w_last_pix) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (r_idx == IDX_W'(NUM_PAT - 1)) w_state_nxt = S_FIN;
                else                              w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_idx     <= '0;
            r_h0      <= '0;
            r_v0      <= '0;
            r_sw      <= '0;
            r_sh      <= '0;
            r_tw      <= '0;
            r_th      <= '0;
            r_wcnt    <= '0;
            r_cyc     <= '0;
            r_addr    <= '0;
            r_cmp_vld <= 1'b0;
            r_err     <= '0;
            r_timeout <= 1'b0;
            r_proto   <= 1'b0;
        end else begin
            // Read data returns one cycle after RD_EN, so the compare strobe trails it by one
            r_cmp_vld <= (r_state == S_CHK);
            if (w_start_run) begin
                r_idx     <= '0;
                r_err     <= '0;
                r_timeout <= 1'b0;
                r_proto   <= 1'b0;
            end
            if (w_set_to) r_timeout <= 1'b1;
            if (w_set_pe) r_proto   <= 1'b1;
            if (r_state == S_NEXT && w_state_nxt == S_LOAD) r_idx <= r_idx + 1'b1;
            if (r_cmp_vld && w_mismatch && (r_err != '1)) r_err <= r_err + 1'b1;
            case (r_state)
                S_LOAD: begin
                    r_h0   <= CFG_H0;
                    r_v0   <= CFG_V0;
                    r_sw   <= CFG_SW;
                    r_sh   <= CFG_SH;
                    r_tw   <= CFG_TW;
                    r_th   <= CFG_TH;
                    r_cyc  <= '0;
                    r_wcnt <= '0;
                end
                S_DRST: r_wcnt <= (w_state_nxt == S_WLOW) ? '0 : r_wcnt + 1'b1;
                S_WLOW: begin
                    if (w_state_nxt == S_WLOW) r_wcnt <= r_wcnt + 1'b1;
                end
                S_RUN: begin
                    if (w_state_nxt == S_RUN) r_cyc <= r_cyc + 1'b1;
                    r_addr <= '0;
                end
                S_CHK: r_addr <= r_addr + 1'b1;
                default: ;
            endcase
        end
    end

    assign CFG_IDX   = r_idx;
    assign H0        = r_h0;
    assign V0        = r_v0;
    assign SW        = r_sw;
    assign SH        = r_sh;
    assign TW        = r_tw;
    assign TH        = r_th;
    assign RD_EN     = (r_state == S_CHK);
    assign RD_ADDR   = r_addr[ADDR_W-1:0];
    assign DUT_RST   = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DRST) ||
                       (r_state == S_NEXT) || (r_state == S_FIN);
    assign BUSY      = (r_state != S_IDLE) && (r_state != S_FIN);
    assign END       = (r_state == S_FIN);
    assign TIMEOUT   = r_timeout;
    assign PROTO_ERR = r_proto;
    assign ERR_CNT   = r_err;
    assign PASS      = END && (r_err == '0) && !r_timeout && !r_proto;

endmodule
